// File: rtl/spi_burst_register_bank.sv
// SPI mode-0 slave exposing a bank of 8-bit registers with burst read/write access.
// SPI pins are oversampled on i_clk_10; edges are detected after a short synchroniser.
module spi_burst_register_bank #(
  parameter int                N_REGS      = 16,
  parameter logic [7:0]        RST_VAL     = 8'h00,
  parameter logic [N_REGS-1:0] RO_MASK     = {N_REGS{1'b0}},
  parameter int                SYNC_STAGES = 2
) (
  input  logic                  i_clk_10,
  input  logic                  i_rst,
  input  logic                  i_SCLK,
  input  logic                  i_SSEL,
  input  logic                  i_MOSI,
  output logic                  o_MISO,
  input  logic [8*N_REGS-1:0]   i_ro_data,
  output logic [8*N_REGS-1:0]   o_regs,
  output logic                  o_wr_stb,
  output logic [6:0]            o_wr_addr,
  output logic                  o_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

  localparam logic [6:0] LAST_ADDR = 7'(N_REGS - 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ssel_sync_q, ssel_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ssel_prev_q, ssel_prev_d;

  state_t                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             rx_q, rx_d;
  logic [6:0]             addr_q, addr_d;
  logic                   is_write_q, is_write_d;
  logic [7:0]             miso_sr_q, miso_sr_d;
  logic                   miso_en_q, miso_en_d;
  logic                   skip_fall_q, skip_fall_d;
  logic                   wr_stb_q, wr_stb_d;
  logic [6:0]             wr_addr_q, wr_addr_d;
  logic [7:0]             regs_q [N_REGS];
  logic [7:0]             regs_d [N_REGS];

  logic       sclk_s, ssel_s, mosi_s;
  logic       sclk_rise, sclk_fall, ssel_fall, ssel_rise;
  logic [7:0] rx_byte;
  logic [6:0] next_addr;
  logic [6:0] look_addr;
  logic [7:0] look_val;
  logic       addr_hit, addr_ro, commit;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ssel_s    = ssel_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s &  sclk_prev_q;
  assign ssel_fall = ~ssel_s &  ssel_prev_q;
  assign ssel_rise =  ssel_s & ~ssel_prev_q;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_SCLK};
    ssel_sync_d = {ssel_sync_q[SYNC_STAGES-2:0], i_SSEL};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_MOSI};
    sclk_prev_d = sclk_s;
    ssel_prev_d = ssel_s;

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    addr_d      = addr_q;
    is_write_d  = is_write_q;
    miso_sr_d   = miso_sr_q;
    miso_en_d   = miso_en_q;
    skip_fall_d = skip_fall_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    regs_d      = regs_q;
    commit      = 1'b0;

    rx_byte   = {rx_q, mosi_s};
    next_addr = (addr_q == LAST_ADDR) ? 7'd0 : addr_q + 7'd1;
    // At CMD completion the read pointer is the address just received, otherwise the next burst slot.
    look_addr = (state_q == ST_CMD) ? rx_byte[6:0] : next_addr;

    look_val = 8'h00;
    addr_hit = 1'b0;
    addr_ro  = 1'b0;
    for (int k = 0; k < N_REGS; k++) begin
      if (look_addr == 7'(k)) look_val = RO_MASK[k] ? i_ro_data[8*k +: 8] : regs_q[k];
      if (addr_q == 7'(k)) begin
        addr_hit = 1'b1;
        addr_ro  = RO_MASK[k];
      end
    end

    if (ssel_fall) begin
      state_d     = ST_CMD;
      bit_cnt_d   = 3'd0;
      miso_en_d   = 1'b0;
      skip_fall_d = 1'b0;
    end else if (ssel_rise) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 3'd0;
      miso_en_d   = 1'b0;
      skip_fall_d = 1'b0;
    end else if (state_q != ST_IDLE) begin
      if (sclk_rise) begin
        rx_d      = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          skip_fall_d = 1'b1;
          miso_sr_d   = look_val;
          if (state_q == ST_CMD) begin
            state_d    = ST_DATA;
            is_write_d = rx_byte[7];
            addr_d     = rx_byte[6:0];
            miso_en_d  = ~rx_byte[7];
          end else begin
            if (is_write_q && addr_hit && !addr_ro) begin
              commit    = 1'b1;
              wr_stb_d  = 1'b1;
              wr_addr_d = addr_q;
            end
            addr_d = next_addr;
          end
        end
      end else if (sclk_fall && state_q == ST_DATA) begin
        // The master samples the freshly loaded MSB on the next rising edge, so hold it one fall.
        if (skip_fall_q) skip_fall_d = 1'b0;
        else             miso_sr_d   = {miso_sr_q[6:0], 1'b0};
      end
    end

    for (int k = 0; k < N_REGS; k++) begin
      if (commit && addr_q == 7'(k)) regs_d[k] = rx_byte;
    end
  end

  // Synchronisers reset to 0 so an SSEL already low at reset release is not seen as a new frame.
  always_ff @(posedge i_clk_10 or posedge i_rst) begin
    if (i_rst) begin
      sclk_sync_q <= '0;
      ssel_sync_q <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ssel_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 7'd0;
      addr_q      <= 7'd0;
      is_write_q  <= 1'b0;
      miso_sr_q   <= 8'h00;
      miso_en_q   <= 1'b0;
      skip_fall_q <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= 7'd0;
      for (int k = 0; k < N_REGS; k++) regs_q[k] <= RST_VAL;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ssel_sync_q <= ssel_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ssel_prev_q <= ssel_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      addr_q      <= addr_d;
      is_write_q  <= is_write_d;
      miso_sr_q   <= miso_sr_d;
      miso_en_q   <= miso_en_d;
      skip_fall_q <= skip_fall_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      regs_q      <= regs_d;
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_regs_out
    assign o_regs[8*g +: 8] = RO_MASK[g] ? i_ro_data[8*g +: 8] : regs_q[g];
  end

  assign o_MISO    = miso_en_q & miso_sr_q[7];
  assign o_wr_stb  = wr_stb_q;
  assign o_wr_addr = wr_addr_q;
  assign o_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_burst_register_bank.sv
// Directed bench for spi_burst_register_bank: drives SPI mode-0 frames and checks
// register contents, write strobes and MISO read-back against hand-computed values.
module tb_spi_burst_register_bank;

  localparam int          N_REGS = 16;
  localparam logic [7:0]  RSTV   = 8'h3C;
  localparam time         HALF   = 400ns;

  logic                  clk;
  logic                  rst;
  logic                  sclk;
  logic                  ssel;
  logic                  mosi;
  logic                  miso;
  logic [8*N_REGS-1:0]   ro_data;
  logic [8*N_REGS-1:0]   regs;
  logic                  wr_stb;
  logic [6:0]            wr_addr;
  logic                  busy;

  int compared   = 0;
  int mismatched = 0;
  int stb_cycles = 0;
  int stb_pulses = 0;
  logic stb_prev = 1'b0;

  logic [7:0] tx_buf [8];
  logic [7:0] rx_buf [8];
  logic [7:0] rx_tmp;
  int         base_pulses;
  int         base_cycles;

  spi_burst_register_bank #(
    .N_REGS(N_REGS),
    .RST_VAL(RSTV),
    .RO_MASK(16'h0004),
    .SYNC_STAGES(2)
  ) dut (
    .i_clk_10(clk),
    .i_rst(rst),
    .i_SCLK(sclk),
    .i_SSEL(ssel),
    .i_MOSI(mosi),
    .o_MISO(miso),
    .i_ro_data(ro_data),
    .o_regs(regs),
    .o_wr_stb(wr_stb),
    .o_wr_addr(wr_addr),
    .o_busy(busy)
  );

  // 10 MHz system clock
  initial clk = 1'b0;
  always #50ns clk = ~clk;

  // Strobe monitor: counts high cycles and distinct pulses so pulse width can be checked
  always @(negedge clk) begin
    if (wr_stb) stb_cycles = stb_cycles + 1;
    if (wr_stb && !stb_prev) stb_pulses = stb_pulses + 1;
    stb_prev = wr_stb;
  end

  function automatic logic [7:0] reg_byte(input int k);
    return regs[8*k +: 8];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Shift nbits of tx (MSB first); MISO is sampled just before each rising edge
  task automatic sendBits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      #HALF;
      rx[i] = miso;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic applyStimulus(input int n);
    ssel = 1'b0;
    #HALF;
    for (int b = 0; b < n; b++) sendBits(tx_buf[b], 8, rx_buf[b]);
    #HALF;
    ssel = 1'b1;
    #(2*HALF);
  endtask

  task automatic markStrobes;
    base_pulses = stb_pulses;
    base_cycles = stb_cycles;
  endtask

  initial begin
    rst     = 1'b1;
    sclk    = 1'b0;
    ssel    = 1'b1;
    mosi    = 1'b0;
    ro_data = '0;
    ro_data[8*2 +: 8] = 8'hA5;
    #13ns;
    #300ns;

    // Reset state
    checkOutput("rst_miso",    32'(miso),        32'h0);
    checkOutput("rst_stb",     32'(wr_stb),      32'h0);
    checkOutput("rst_wr_addr", 32'(wr_addr),     32'h0);
    checkOutput("rst_busy",    32'(busy),        32'h0);
    checkOutput("rst_reg0",    32'(reg_byte(0)), 32'(RSTV));
    checkOutput("rst_reg2_ro", 32'(reg_byte(2)), 32'hA5);
    rst = 1'b0;
    #(2*HALF);

    // Single write {0x83, 0x5A}
    markStrobes();
    tx_buf[0] = 8'h83; tx_buf[1] = 8'h5A;
    ssel = 1'b0;
    #HALF;
    checkOutput("busy_in_frame", 32'(busy), 32'h1);
    for (int b = 0; b < 2; b++) sendBits(tx_buf[b], 8, rx_buf[b]);
    #HALF;
    ssel = 1'b1;
    #(2*HALF);
    checkOutput("sw_reg3",     32'(reg_byte(3)),          32'h5A);
    checkOutput("sw_pulses",   32'(stb_pulses - base_pulses), 32'd1);
    checkOutput("sw_width",    32'(stb_cycles - base_cycles), 32'd1);
    checkOutput("sw_addr",     32'(wr_addr),              32'd3);
    checkOutput("sw_reg4",     32'(reg_byte(4)),          32'(RSTV));
    checkOutput("sw_miso0",    32'(rx_buf[1]),            32'h00);
    checkOutput("sw_busy_end", 32'(busy),                 32'h0);

    // Burst write with wrap {0x8E, 0x11, 0x22, 0x33}
    markStrobes();
    tx_buf[0] = 8'h8E; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33;
    applyStimulus(4);
    checkOutput("bw_reg14",  32'(reg_byte(14)), 32'h11);
    checkOutput("bw_reg15",  32'(reg_byte(15)), 32'h22);
    checkOutput("bw_reg0",   32'(reg_byte(0)),  32'h33);
    checkOutput("bw_reg1",   32'(reg_byte(1)),  32'(RSTV));
    checkOutput("bw_pulses", 32'(stb_pulses - base_pulses), 32'd3);
    checkOutput("bw_addr",   32'(wr_addr),      32'd0);

    // Burst read with wrap {0x0F, 0x00, 0x00}
    markStrobes();
    tx_buf[0] = 8'h0F; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    applyStimulus(3);
    checkOutput("br_cmd_miso", 32'(rx_buf[0]), 32'h00);
    checkOutput("br_byte0",    32'(rx_buf[1]), 32'h22);
    checkOutput("br_byte1",    32'(rx_buf[2]), 32'h33);
    checkOutput("br_pulses",   32'(stb_pulses - base_pulses), 32'd0);

    // Read-only write dropped, read-only and unmapped read-back
    markStrobes();
    tx_buf[0] = 8'h82; tx_buf[1] = 8'hFF;
    applyStimulus(2);
    checkOutput("ro_pulses", 32'(stb_pulses - base_pulses), 32'd0);
    checkOutput("ro_addr",   32'(wr_addr), 32'd0);
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h00;
    applyStimulus(2);
    checkOutput("ro_read", 32'(rx_buf[1]), 32'hA5);
    tx_buf[0] = 8'h40; tx_buf[1] = 8'h00;
    applyStimulus(2);
    checkOutput("unmap_read", 32'(rx_buf[1]), 32'h00);
    tx_buf[0] = 8'hC0; tx_buf[1] = 8'h77;
    applyStimulus(2);
    checkOutput("unmap_wr_pulses", 32'(stb_pulses - base_pulses), 32'd0);

    // Abort mid-byte, then a clean retry
    markStrobes();
    ssel = 1'b0;
    #HALF;
    sendBits(8'h85, 8, rx_tmp);
    sendBits(8'hC3, 4, rx_tmp);
    #HALF;
    ssel = 1'b1;
    #(2*HALF);
    checkOutput("ab_reg5",   32'(reg_byte(5)), 32'(RSTV));
    checkOutput("ab_pulses", 32'(stb_pulses - base_pulses), 32'd0);
    checkOutput("ab_busy",   32'(busy), 32'h0);
    tx_buf[0] = 8'h85; tx_buf[1] = 8'hC3;
    applyStimulus(2);
    checkOutput("ab_retry_reg5", 32'(reg_byte(5)), 32'hC3);
    checkOutput("ab_retry_addr", 32'(wr_addr),     32'd5);
    checkOutput("ab_retry_pul",  32'(stb_pulses - base_pulses), 32'd1);

    // Reset during the second data byte of a burst write
    ssel = 1'b0;
    #HALF;
    sendBits(8'h81, 8, rx_tmp);
    sendBits(8'hAA, 8, rx_tmp);
    sendBits(8'hBB, 4, rx_tmp);
    checkOutput("mr_reg1_pre", 32'(reg_byte(1)), 32'hAA);
    rst = 1'b1;
    #20ns;
    checkOutput("mr_reg1",    32'(reg_byte(1)), 32'(RSTV));
    checkOutput("mr_reg5",    32'(reg_byte(5)), 32'(RSTV));
    checkOutput("mr_reg0",    32'(reg_byte(0)), 32'(RSTV));
    checkOutput("mr_busy",    32'(busy),        32'h0);
    checkOutput("mr_stb",     32'(wr_stb),      32'h0);
    checkOutput("mr_wr_addr", 32'(wr_addr),     32'h0);
    checkOutput("mr_miso",    32'(miso),        32'h0);
    #280ns;
    rst = 1'b0;
    markStrobes();
    sendBits(8'hBB, 4, rx_tmp);
    sendBits(8'hCC, 8, rx_tmp);
    checkOutput("mr_busy_after", 32'(busy), 32'h0);
    #HALF;
    ssel = 1'b1;
    #(2*HALF);
    checkOutput("mr_pulses",     32'(stb_pulses - base_pulses), 32'd0);
    checkOutput("mr_reg1_after", 32'(reg_byte(1)), 32'(RSTV));
    tx_buf[0] = 8'h81; tx_buf[1] = 8'h77;
    applyStimulus(2);
    checkOutput("mr_fresh_reg1",   32'(reg_byte(1)), 32'h77);
    checkOutput("mr_fresh_pulses", 32'(stb_pulses - base_pulses), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_burst_register_bank.md
SPI_BURST_REGISTER_BANK -- requirements
Module: spi_burst_register_bank

Interface
REQ-001 SHALL have parameter N_REGS, default 16, number of 8-bit registers (legal 2..128).
REQ-002 SHALL have parameter RST_VAL, default 8'h00, reset value of every writable register.
REQ-003 SHALL have parameter RO_MASK, default {N_REGS{1'b0}}; bit k=1 makes register k read-only.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for SCLK/SSEL/MOSI (legal 2..3).
REQ-005 SHALL have port i_clk_10  input  1  system clock (10 MHz).
REQ-006 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port i_SCLK  input  1  SPI clock, mode 0, asynchronous to i_clk_10.
REQ-008 SHALL have port i_SSEL  input  1  SPI select, active low.
REQ-009 SHALL have port i_MOSI  input  1  SPI data in, MSB first.
REQ-010 SHALL have port o_MISO  output  1  SPI data out, MSB first.
REQ-011 SHALL have port i_ro_data  input  8*N_REGS  read-back value for registers flagged in RO_MASK; byte k = bits [8k+7:8k].
REQ-012 SHALL have port o_regs  output  8*N_REGS  current value of all registers, same packing.
REQ-013 SHALL have port o_wr_stb  output  1  one-cycle pulse per committed write.
REQ-014 SHALL have port o_wr_addr  output  7  address of last committed write.
REQ-015 SHALL have port o_busy  output  1  high while a frame is active (synchronised SSEL low).

Function
REQ-016 SHALL synchronise i_SCLK, i_SSEL and i_MOSI through SYNC_STAGES flops, detect SCLK edges on i_clk_10, and sample MOSI on detected SCLK rising edges.
REQ-017 SHALL support SCLK half-period >= 3 i_clk_10 periods.
REQ-018 SHALL implement FSM IDLE -> CMD (on SSEL falling) -> DATA (after 8th CMD bit) -> DATA (each further byte); any SSEL rising returns to IDLE.
REQ-019 SHALL interpret CMD byte as bit7 = write(1)/read(0), bits6:0 = start address.
REQ-020 SHALL treat every byte after CMD within one frame as a burst data byte, post-incrementing the address after each byte.
REQ-021 SHALL wrap the address from N_REGS-1 to 0; unmapped addresses (>= N_REGS) increment modulo 128.
REQ-022 SHALL commit a write one i_clk_10 cycle after the detected 8th rising edge of a data byte: o_regs byte updated, o_wr_stb=1 for exactly one cycle, o_wr_addr = address.
REQ-023 SHALL drop writes to RO_MASK registers and unmapped addresses with no o_wr_stb pulse.
REQ-024 SHALL, in read frames, load the MISO shift register with the current-address value at CMD completion and at each data-byte completion, and drive its MSB on o_MISO immediately.
REQ-025 SHALL shift o_MISO on detected SCLK falling edges except the falling edge directly following a byte's 8th rising edge.
REQ-026 SHALL return i_ro_data byte for RO_MASK registers, the stored value otherwise, and 8'h00 for unmapped addresses.
REQ-027 SHALL drive o_MISO=0 during CMD phase, write frames and IDLE.
REQ-028 SHALL discard a partial byte when SSEL rises mid-byte: no write, no address change, bit counter cleared.
REQ-029 SHALL restart cleanly at CMD on a new SSEL falling edge regardless of prior frame state.

Reset
REQ-030 SHALL on i_rst=1 immediately set all writable registers to RST_VAL, o_MISO=0, o_wr_stb=0, o_wr_addr=0, o_busy=0, FSM=IDLE, bit counter=0.
REQ-031 SHALL abort any in-flight frame on reset; after reset release, a frame starts only on a fresh SSEL falling edge.

Verification
REQ-032 Single write: frame {0x83, 0x5A} -> reg3=0x5A, one o_wr_stb pulse, o_wr_addr=3, others RST_VAL.
REQ-033 Burst write with wrap (N_REGS=16): frame {0x8E, 0x11, 0x22, 0x33} -> reg14=0x11, reg15=0x22, reg0=0x33, three strobes.
REQ-034 Burst read: after REQ-033, frame {0x0F, 0x00, 0x00} -> MISO returns 0x22 then 0x33, no strobes.
REQ-035 Read-only/unmapped: RO_MASK bit2=1, i_ro_data byte2=0xA5; frame {0x82, 0xFF} -> no strobe, reg2 read returns 0xA5; read of address 0x40 returns 0x00.
REQ-036 Abort: SSEL raised after 4 bits of data byte in {0x85, 0xC3...} -> reg5 unchanged, no strobe, next frame {0x85, 0xC3} writes 0xC3.
REQ-037 Reset mid-burst: assert i_rst during second data byte -> all outputs at reset values, registers = RST_VAL, no strobe after release.
